// File: rtl/apb_slave.sv
// Zero-wait-state APB slave over a 2**ADDR_WIDTH x DATA_WIDTH register memory.
// prdata is registered on the setup phase of a read so it is valid across the access phase.
module apb_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = IDLE;
    case (state)
      IDLE:    if (psel && !penable) state_nxt = SETUP;
      SETUP:   if (!psel)            state_nxt = IDLE;
               else if (penable)     state_nxt = ACCESS;
               else                  state_nxt = SETUP;
      ACCESS:  if (psel && !penable) state_nxt = SETUP;
      default: state_nxt = IDLE;
    endcase
  end

  // The state lags the bus by one edge: SETUP with penable high is the bus access phase.
  assign wr_en = (state == SETUP) && psel && penable && pwrite;
  assign rd_en = psel && !penable && !pwrite;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)     prdata <= '0;
    else if (rd_en) prdata <= mem[paddr];
  end

  // NOTE: the memory is built from resettable flops because every word must read zero straight out of reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[paddr] <= pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: directed scenarios plus randomized transfers
// checked against a transaction-level memory model.
module tb_apb_slave;

  logic        pclk;
  logic        rst_n;
  logic [7:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] last_rd;
  logic [7:0]  written_q [$];

  apb_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
    .prdata  (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    last_rd = '0;
    written_q.delete();
  endtask

  task automatic drive(input logic s, input logic e, input logic w,
                       input logic [7:0] a, input logic [31:0] d);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input string tag);
    drive(1'b1, 1'b0, 1'b1, a, d);
    tick();
    drive(1'b1, 1'b1, 1'b1, a, d);
    @(negedge pclk);
    check({tag, "_hold"}, prdata, last_rd);
    tick();
    model_mem[a] = d;
    written_q.push_back(a);
  endtask

  task automatic apb_read(input logic [7:0] a, input string tag);
    drive(1'b1, 1'b0, 1'b0, a, $urandom);
    tick();
    drive(1'b1, 1'b1, 1'b0, a, $urandom);
    @(negedge pclk);
    check(tag, prdata, model_mem[a]);
    last_rd = model_mem[a];
    tick();
  endtask

  // Bus noise with psel low: none of it may change memory or prdata.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), $urandom);
      if (i == n - 1) begin
        @(negedge pclk);
        check("idle_hold", prdata, last_rd);
      end
      tick();
    end
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;

    model_clear();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) @(posedge pclk);
    #2;
    check("reset_prdata", prdata, 32'h0);
    @(negedge pclk);
    rst_n = 1'b1;
    tick();

    // Freshly reset memory reads zero.
    apb_read(8'h10, "rd_reset_10");

    apb_write(8'h05, 32'hDEADBEEF, "wr_05");
    apb_read(8'h05, "rd_05");
    idle(1);

    // Back-to-back writes then reads, no idle between transfers.
    apb_write(8'h01, 32'h11111111, "wr_01");
    apb_write(8'hFF, 32'h22222222, "wr_ff");
    apb_read(8'h01, "rd_01");
    apb_read(8'hFF, "rd_ff");
    apb_read(8'h00, "rd_00");
    idle(2);

    // penable without psel must not write.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 8'h07, 32'hA5A5A5A5);
      tick();
    end
    apb_read(8'h07, "rd_07_nosel");
    idle(1);

    // Held penable after a write: no second access, FSM falls to IDLE,
    // where a further psel+penable cycle is also ignored.
    apb_write(8'h20, 32'h12345678, "wr_20");
    drive(1'b1, 1'b1, 1'b1, 8'h20, 32'h0);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, 8'h20, 32'hBAD0BAD0);
    tick();
    apb_read(8'h20, "rd_20_held");
    idle(1);

    // Illegal psel+penable straight from IDLE performs no access.
    drive(1'b1, 1'b1, 1'b1, 8'h44, 32'h5555AAAA);
    tick();
    apb_read(8'h44, "rd_44_illegal");
    idle(1);

    // Randomized transfers with random gaps and back-to-back runs.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = 8'($urandom);
          d = $urandom;
          apb_write(a, d, "rnd_wr");
        end
        2: begin
          if (written_q.size() > 0 && $urandom_range(0, 1) == 1)
            a = written_q[$urandom_range(0, written_q.size() - 1)];
          else
            a = 8'($urandom);
          apb_read(a, "rnd_rd");
        end
        default: idle($urandom_range(1, 3));
      endcase
    end
    idle(1);

    // Reset asserted between edges aborts an in-flight write and clears everything.
    apb_write(8'h30, 32'hCAFEF00D, "wr_30");
    apb_read(8'h30, "rd_30");
    drive(1'b1, 1'b0, 1'b1, 8'h31, 32'h0BADF00D);
    tick();
    drive(1'b1, 1'b1, 1'b1, 8'h31, 32'h0BADF00D);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_prdata", prdata, 32'h0);
    model_clear();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    tick();
    check("rst_held_prdata", prdata, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    check("rst_release_prdata", prdata, 32'h0);
    apb_read(8'h30, "rd_30_after_rst");
    apb_read(8'h31, "rd_31_aborted");
    apb_read(8'h05, "rd_05_after_rst");
    apb_write(8'h31, 32'h600DCAFE, "wr_31_resume");
    apb_read(8'h31, "rd_31_resume");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
